// File: rtl/multinomial_dmas_pixel_level_pkg.sv
// Shared widths, sign encodings, sequencer states and the integer square-root helper
// for the pixel-level DMAS beamformer.
package multinomial_dmas_pixel_level_pkg;

    localparam int unsigned DIN_W   = 16;
    localparam int unsigned ROOT_W  = 8;
    localparam int unsigned SUM_W   = 16;
    localparam int unsigned SQSUM_W = 24;
    localparam int unsigned OUT_W   = 17;
    localparam int unsigned PROD_W  = 34;

    localparam logic [1:0] SIGN_POS = 2'b01;
    localparam logic [1:0] SIGN_NEG = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Floor square root, one result bit decided per iteration from the MSB down.
    function automatic logic [ROOT_W-1:0] isqrt(input logic [DIN_W-1:0] x);
        logic [ROOT_W-1:0] res;
        logic [ROOT_W-1:0] trial;
        res = '0;
        for (int b = ROOT_W - 1; b >= 0; b--) begin
            trial = res | (ROOT_W'(1) << b);
            if (DIN_W'(trial) * DIN_W'(trial) <= x) begin
                res = trial;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/multinomial_dmas_pixel_level_int_sqrt_pipe.sv
// Floor integer square root of a 16-bit magnitude, presented after a fixed
// number of register stages.
module int_sqrt_pipe
    import multinomial_dmas_pixel_level_pkg::*;
#(
    parameter int unsigned latency = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    output logic [ROOT_W-1:0] root
);

    logic [ROOT_W-1:0] stage [latency];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(latency); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= isqrt(din);
            for (int i = 1; i < int'(latency); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign root = stage[latency-1];

endmodule

// File: rtl/multinomial_dmas_pixel_level.sv
// Single-pixel DMAS beamformer: sums pairwise products of signed square-rooted
// channel samples via (S*S - Q)/2, then scales and saturates to 17 bits.
module multinomial_dmas_pixel_level
    import multinomial_dmas_pixel_level_pkg::*;
#(
    parameter int unsigned channels        = 128,
    parameter int unsigned channel_bits    = 8,
    parameter int unsigned pixels          = 1,
    parameter int unsigned datasize        = channels,
    parameter int unsigned sqrt_ip_latency = 5,
    parameter int unsigned OUT_SHIFT       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIN_W-1:0]        chnl_din,
    input  logic [1:0]              sign,
    output logic signed [OUT_W-1:0] bf_out
);

    localparam int unsigned WIN     = channels + 3;
    localparam int unsigned K_ACC   = WIN + sqrt_ip_latency;
    localparam int unsigned K_OUT   = WIN + sqrt_ip_latency + 3;
    localparam int unsigned K_SAT   = K_OUT + 1;
    localparam bit          CFG_OK  = (pixels == 1) && (datasize > 0);

    localparam logic [channel_bits-1:0] CNT_WIN = channel_bits'(WIN);
    localparam logic [channel_bits-1:0] CNT_ACC = channel_bits'(K_ACC);
    localparam logic [channel_bits-1:0] CNT_OUT = channel_bits'(K_OUT);
    localparam logic [channel_bits-1:0] CNT_SAT = channel_bits'(K_SAT);

    localparam logic signed [PROD_W-1:0] OUT_MAX = PROD_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] OUT_MIN = PROD_W'(-(2 ** (OUT_W - 1)));

    logic [channel_bits-1:0]    cnt;
    logic [1:0]                 state_q;
    logic [1:0]                 state_d;
    logic [DIN_W-1:0]           samp_din;
    logic [1:0]                 samp_sign;
    logic [1:0]                 sign_dly [sqrt_ip_latency];
    logic [ROOT_W-1:0]          root;
    logic [1:0]                 root_sign;
    logic signed [SUM_W-1:0]    s_term;
    logic [SQSUM_W-1:0]         r_sq;
    logic signed [SUM_W-1:0]    acc_s;
    logic [SQSUM_W-1:0]         acc_q;
    logic signed [PROD_W-1:0]   sq_q;
    logic signed [PROD_W-1:0]   diff;
    logic signed [PROD_W-1:0]   scaled;
    logic signed [OUT_W-1:0]    comb_d;
    logic signed [OUT_W-1:0]    comb_q;

    // Cycle counter; stops once the result has been issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt < CNT_SAT) begin
            cnt <= cnt + channel_bits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_ACCUM;
            ST_ACCUM: if (cnt == CNT_ACC) state_d = ST_FINAL;
            ST_FINAL: if (cnt == CNT_OUT) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Input capture: anything outside the channel window enters as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_din  <= '0;
            samp_sign <= '0;
        end else if (CFG_OK && (cnt < CNT_WIN)) begin
            samp_din  <= chnl_din;
            samp_sign <= sign;
        end else begin
            samp_din  <= '0;
            samp_sign <= '0;
        end
    end

    int_sqrt_pipe #(
        .latency (sqrt_ip_latency)
    ) u_sqrt (
        .clk  (clk),
        .rst  (rst),
        .din  (samp_din),
        .root (root)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(sqrt_ip_latency); i++) begin
                sign_dly[i] <= '0;
            end
        end else begin
            sign_dly[0] <= samp_sign;
            for (int i = 1; i < int'(sqrt_ip_latency); i++) begin
                sign_dly[i] <= sign_dly[i-1];
            end
        end
    end

    assign root_sign = sign_dly[sqrt_ip_latency-1];

    always_comb begin
        s_term = '0;
        if (root_sign == SIGN_POS) begin
            s_term = SUM_W'(root);
        end else if (root_sign[1] == SIGN_NEG[1]) begin
            s_term = SUM_W'(0) - SUM_W'(root);
        end
        r_sq = SQSUM_W'(root) * SQSUM_W'(root);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_s <= '0;
            acc_q <= '0;
        end else if (state_q == ST_ACCUM) begin
            acc_s <= acc_s + s_term;
            acc_q <= acc_q + r_sq;
        end
    end

    // (S*S - Q) / 2 is the sum of all cross products s_i*s_j, i<j.
    always_comb begin
        diff   = sq_q - $signed(PROD_W'(acc_q));
        scaled = (diff >>> 1) >>> OUT_SHIFT;
        comb_d = OUT_W'(scaled);
        if (scaled > OUT_MAX) begin
            comb_d = OUT_W'(OUT_MAX);
        end else if (scaled < OUT_MIN) begin
            comb_d = OUT_W'(OUT_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_q   <= '0;
            comb_q <= '0;
        end else if (state_q == ST_FINAL) begin
            sq_q   <= $signed({{(PROD_W - SUM_W){acc_s[SUM_W-1]}}, acc_s}) *
                      $signed({{(PROD_W - SUM_W){acc_s[SUM_W-1]}}, acc_s});
            comb_q <= comb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bf_out <= '0;
        end else if ((state_q == ST_FINAL) && (cnt == CNT_OUT)) begin
            bf_out <= comb_q;
        end
    end

endmodule

// File: tb/tb_multinomial_dmas_pixel_level.sv
// Scoreboard bench: stimulus pushes the expected bf_out per cycle, a monitor
// pops and compares after every rising edge.
module tb_multinomial_dmas_pixel_level;
    import multinomial_dmas_pixel_level_pkg::*;

    localparam int L     = 5;
    localparam int W     = 128 + 3;
    localparam int K_OUT = W + L + 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        chnl_din = '0;
    logic [1:0]         sign = '0;
    logic signed [16:0] bf_out;
    logic [15:0]        sq_din = '0;
    logic [7:0]         sq_root;

    typedef struct {
        int k;
        int tag;
        int val;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multinomial_dmas_pixel_level #(
        .channels        (128),
        .channel_bits    (8),
        .pixels          (1),
        .datasize        (128),
        .sqrt_ip_latency (L),
        .OUT_SHIFT       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .chnl_din (chnl_din),
        .sign     (sign),
        .bf_out   (bf_out)
    );

    int_sqrt_pipe #(.latency(L)) u_sqrt (
        .clk  (clk),
        .rst  (rst),
        .din  (sq_din),
        .root (sq_root)
    );

    // Monitor: one expected value per rising edge while the queue is non-empty.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (int'(bf_out) != e.val) begin
                    errors++;
                    $display("FAIL bf_out tag=%0d k=%0d got %0d expected %0d",
                             e.tag, e.k, int'(bf_out), e.val);
                end
            end
        end
    end

    function automatic void pat(input int p, input int k,
                                output logic [15:0] d, output logic [1:0] s);
        d = 16'd0;
        s = 2'b00;
        if (k >= W) begin
            d = 16'hFFFF;
            s = SIGN_POS;
            return;
        end
        case (p)
            1: if (k == 0) begin d = 16'd10000; s = SIGN_POS; end
            2: if (k == 5 || k == 7) begin d = 16'd4096; s = SIGN_POS; end
            3: begin
                if (k == 5) begin d = 16'd4096; s = SIGN_POS; end
                if (k == 7) begin d = 16'd4096; s = SIGN_NEG; end
            end
            4: if (k < 128) begin d = 16'd32767; s = SIGN_POS; end
            5: if (k == 0 || k == W - 1) begin d = 16'd4096; s = SIGN_POS; end
            6: if (k < 128) begin d = 16'hFFFF; s = (k % 2 == 0) ? SIGN_POS : SIGN_NEG; end
            7: begin
                if (k == 0) begin d = 16'd4096; s = SIGN_POS; end
                if (k == 2) begin d = 16'd4096; s = 2'b10; end
            end
            default: ;
        endcase
    endfunction

    task automatic do_reset();
        repeat (2) begin
            @(negedge clk);
            rst = 1'b1;
            chnl_din = '0;
            sign = '0;
            expq.push_back('{-1, -1, 0});
        end
    endtask

    // One pixel run; abort_at >= 0 asserts rst before that edge and ends the run.
    task automatic run(input int p, input int expv, input int abort_at, input int tag);
        logic [15:0] d;
        logic [1:0]  s;
        for (int k = 0; k <= K_OUT + 2; k++) begin
            @(negedge clk);
            rst = 1'b0;
            if (k == abort_at) begin
                rst = 1'b1;
                chnl_din = '0;
                sign = '0;
                expq.push_back('{k, tag, 0});
                return;
            end
            pat(p, k, d, s);
            chnl_din = d;
            sign = s;
            expq.push_back('{k, tag, (k >= K_OUT) ? expv : 0});
        end
    endtask

    int sq_in  [7] = '{0, 1, 15, 16, 10000, 32767, 65535};
    int sq_exp [7] = '{0, 1, 3, 4, 100, 181, 255};

    initial begin
        int budget;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sq_din = 16'(sq_in[i]);
            repeat (L) @(posedge clk);
            #1;
            checks++;
            if (int'(sq_root) != sq_exp[i]) begin
                errors++;
                $display("FAIL sqrt in=%0d got %0d expected %0d", sq_in[i], sq_root, sq_exp[i]);
            end
        end

        do_reset();
        run(0, 0, -1, 0);
        do_reset();
        run(1, 0, -1, 1);
        do_reset();
        run(2, 16, -1, 2);
        run(2, 16, 0, 20);
        run(3, -16, -1, 3);
        do_reset();
        run(4, 65535, -1, 4);
        do_reset();
        run(5, 16, -1, 5);
        do_reset();
        run(6, -16257, -1, 6);
        do_reset();
        run(7, -16, -1, 7);
        do_reset();
        run(2, 16, 50, 8);
        run(2, 16, -1, 9);

        budget = 0;
        while (expq.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
